// File: rtl/acc_alu_pkg.sv
// Shared opcode encodings and FSM state type for the accumulator/ALU core.
package acc_alu_pkg;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_ADC  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/acc_alu_comb.sv
// Single-cycle ALU: produces the next accumulator value and flags for one op.
// acc_wr_o/flag_wr_o tell the top which registers the op is allowed to update.
module acc_alu_comb
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             c_o,
    output logic             z_o,
    output logic             acc_wr_o,
    output logic             flag_wr_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        res_o     = acc_i;
        c_o       = 1'b0;
        acc_wr_o  = 1'b1;
        flag_wr_o = 1'b1;
        sum       = '0;
        case (op_i)
            OP_PASS: ;
            OP_LOAD: res_o = b_i;
            OP_ADD: begin
                sum   = {1'b0, acc_i} + {1'b0, b_i};
                res_o = sum[WIDTH-1:0];
                c_o   = sum[WIDTH];
            end
            OP_ADC: begin
                sum   = {1'b0, acc_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
                res_o = sum[WIDTH-1:0];
                c_o   = sum[WIDTH];
            end
            // Top bit of the (WIDTH+1)-bit difference is the borrow; CMP keeps acc.
            OP_SUB, OP_CMP: begin
                sum      = {1'b0, acc_i} - {1'b0, b_i};
                res_o    = sum[WIDTH-1:0];
                c_o      = sum[WIDTH];
                acc_wr_o = (op_i == OP_SUB);
            end
            OP_NAND: res_o = ~(acc_i & b_i);
            OP_SHL: begin
                res_o = {acc_i[WIDTH-2:0], 1'b0};
                c_o   = acc_i[WIDTH-1];
            end
            OP_SHR: begin
                res_o = {1'b0, acc_i[WIDTH-1:1]};
                c_o   = acc_i[0];
            end
            default: begin
                acc_wr_o  = 1'b0;
                flag_wr_o = 1'b0;
            end
        endcase
    end

    assign z_o = ~|res_o;

endmodule

// File: rtl/acc_alu_core.sv
// WIDTH-bit accumulator with registered carry/zero, valid/ready op intake,
// a shift-add multi-cycle multiply and a tri-state view of the accumulator.
module acc_alu_core
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_en,
    input  logic             out_en,
    output wire  [WIDTH-1:0] y,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic                 carry_q;
    logic                 zero_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   prod_d;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH-1:0]     b_eff;
    logic                 accept;
    logic                 last_step;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_z;
    logic                 alu_acc_wr;
    logic                 alu_flag_wr;

    assign b_eff     = b_in & {WIDTH{b_en}};
    assign op_ready  = (state_q == ST_IDLE);
    assign busy      = ~op_ready;
    assign accept    = op_valid & op_ready;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);

    acc_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .acc_i     (acc_q),
        .b_i       (b_eff),
        .c_i       (carry_q),
        .op_i      (op_code),
        .res_o     (alu_res),
        .c_o       (alu_c),
        .z_o       (alu_z),
        .acc_wr_o  (alu_acc_wr),
        .flag_wr_o (alu_flag_wr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_code == OP_MUL) begin
                            state_q  <= ST_MUL;
                            mcand_q  <= {{WIDTH{1'b0}}, acc_q};
                            mplier_q <= b_eff;
                            prod_q   <= '0;
                            cnt_q    <= '0;
                        end else begin
                            if (alu_acc_wr) acc_q <= alu_res;
                            if (alu_flag_wr) begin
                                carry_q <= alu_c;
                                zero_q  <= alu_z;
                            end
                        end
                    end
                end
                // One multiplier bit per cycle; acc/flags are only touched on the last step.
                ST_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        state_q <= ST_IDLE;
                        acc_q   <= prod_d[WIDTH-1:0];
                        carry_q <= |prod_d[2*WIDTH-1:WIDTH];
                        zero_q  <= ~|prod_d[WIDTH-1:0];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign acc   = acc_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign y     = out_en ? acc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_acc_alu_core.sv
// Bench for acc_alu_core (WIDTH=4): directed scenarios plus random op streams
// checked against an arithmetic model of the accumulator and flags.
module tb_acc_alu_core;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [3:0]   op_code;
    logic [W-1:0] b_in;
    logic         b_en;
    logic         out_en;
    wire  [W-1:0] y;
    logic [W-1:0] acc;
    logic         carry;
    logic         zero;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    int m_acc;
    int m_c;
    int m_z;

    // A released bus reads as all-ones.
    pullup pu0 (y[0]);
    pullup pu1 (y[1]);
    pullup pu2 (y[2]);
    pullup pu3 (y[3]);

    acc_alu_core #(.WIDTH(W), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .b_in     (b_in),
        .b_en     (b_en),
        .out_en   (out_en),
        .y        (y),
        .acc      (acc),
        .carry    (carry),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_acc = 0;
        m_c   = 0;
        m_z   = 1;
    endfunction

    function automatic void model_apply(input int op, input int bb);
        int mask;
        int r;
        int s;
        mask = (1 << W) - 1;
        r    = m_acc;
        case (op)
            0: begin r = m_acc; m_c = 0; end
            2: begin r = bb; m_c = 0; end
            3: begin s = m_acc + bb; r = s & mask; m_c = s >> W; end
            5: begin s = m_acc + bb + m_c; r = s & mask; m_c = s >> W; end
            1, 8: begin r = (m_acc - bb) & mask; m_c = (m_acc < bb) ? 1 : 0; end
            4: begin r = ~(m_acc & bb) & mask; m_c = 0; end
            6: begin r = (m_acc << 1) & mask; m_c = (m_acc >> (W - 1)) & 1; end
            7: begin r = m_acc >> 1; m_c = m_acc & 1; end
            9: begin s = m_acc * bb; r = s & mask; m_c = ((s >> W) != 0) ? 1 : 0; end
            default: return;
        endcase
        m_z = (r == 0) ? 1 : 0;
        if (op != 8) m_acc = r;
    endfunction

    // Issue one op, then wait (bounded) until the core is ready again.
    task automatic do_op(input int op, input int b, input bit ben, output int busy_cyc);
        op_code  = 4'(op);
        b_in     = W'(b);
        b_en     = ben;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        model_apply(op, ben ? b : 0);
        busy_cyc = 0;
        while (!op_ready && busy_cyc < 20) begin
            @(posedge clk); #1;
            busy_cyc++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        b_in     = '0;
        b_en     = 1'b1;
        out_en   = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({acc, carry, zero, op_ready, busy} !== {4'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: acc=%0d c=%0b z=%0b rdy=%0b busy=%0b, want 0/0/1/1/0",
                     acc, carry, zero, op_ready, busy);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int bc;
        do_op(2, 3, 1'b1, bc);
        op_code  = 4'd9;
        b_in     = 4'd5;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mul_busy: busy=%0b want 1", busy);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({acc, carry, zero, op_ready, busy} !== {4'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_mul_reset: acc=%0d c=%0b z=%0b rdy=%0b busy=%0b, want 0/0/1/1/0",
                     acc, carry, zero, op_ready, busy);
        end
        #2 reset = 1'b0;
        model_reset();
        repeat (5) begin @(posedge clk); #1; end
        vectors++;
        if ({acc, op_ready} !== {4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_mul_no_partial: acc=%0d rdy=%0b, want 0/1", acc, op_ready);
        end
    endtask

    task automatic test_add_chain();
        int bc;
        int ready_low = 0;
        do_op(2, 9, 1'b1, bc);
        if (!op_ready) ready_low++;
        do_op(3, 8, 1'b1, bc);
        if (!op_ready) ready_low++;
        vectors++;
        if ({acc, carry, zero} !== {4'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add_wrap: acc=%0d c=%0b z=%0b, want 1/1/0", acc, carry, zero);
        end
        do_op(5, 0, 1'b1, bc);
        if (!op_ready) ready_low++;
        vectors++;
        if ({acc, carry, zero} !== {4'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL adc_carry_in: acc=%0d c=%0b z=%0b, want 2/0/0", acc, carry, zero);
        end
        vectors++;
        if (ready_low !== 0) begin
            miscompares++;
            $display("FAIL add_ready_high: low samples=%0d want 0", ready_low);
        end
    endtask

    task automatic test_sub_cmp();
        int bc;
        do_op(2, 3, 1'b1, bc);
        do_op(8, 5, 1'b1, bc);
        vectors++;
        if ({acc, carry, zero} !== {4'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL cmp_lt: acc=%0d c=%0b z=%0b, want 3/1/0", acc, carry, zero);
        end
        do_op(8, 3, 1'b1, bc);
        vectors++;
        if ({acc, carry, zero} !== {4'd3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL cmp_eq: acc=%0d c=%0b z=%0b, want 3/0/1", acc, carry, zero);
        end
        do_op(1, 5, 1'b1, bc);
        vectors++;
        if ({acc, carry, zero} !== {4'd14, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_borrow: acc=%0d c=%0b z=%0b, want 14/1/0", acc, carry, zero);
        end
    endtask

    task automatic test_mul();
        int bc;
        int cyc = 0;
        int held_bad = 0;
        do_op(2, 7, 1'b1, bc);
        op_code  = 4'd9;
        b_in     = 4'd3;
        b_en     = 1'b1;
        op_valid = 1'b1;
        @(posedge clk); #1;
        while (!op_ready && cyc < 20) begin
            if (acc !== 4'd7) held_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 1'b0;
        model_apply(9, 3);
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL mul_busy_cycles: got %0d want 4", cyc);
        end
        vectors++;
        if (held_bad !== 0) begin
            miscompares++;
            $display("FAIL mul_acc_hold: changed in %0d busy cycles, want 0", held_bad);
        end
        vectors++;
        if ({acc, carry, zero} !== {4'd5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mul_result: acc=%0d c=%0b z=%0b, want 5/1/0", acc, carry, zero);
        end
        @(posedge clk); #1;
        vectors++;
        if ({acc, op_ready} !== {4'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL mul_no_reaccept: acc=%0d rdy=%0b, want 5/1", acc, op_ready);
        end
    endtask

    task automatic test_bus();
        int bc;
        do_op(2, 10, 1'b0, bc);
        vectors++;
        if ({acc, zero} !== {4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL b_en_gate: acc=%0d z=%0b, want 0/1", acc, zero);
        end
        out_en = 1'b0; #1;
        vectors++;
        if ({y, acc} !== {4'hF, 4'd0}) begin
            miscompares++;
            $display("FAIL bus_release: y=%b acc=%0d, want y released (1111), acc 0", y, acc);
        end
        out_en = 1'b1; #1;
        vectors++;
        if (y !== 4'd0) begin
            miscompares++;
            $display("FAIL bus_drive_zero: y=%b want 0000", y);
        end
        do_op(2, 6, 1'b1, bc);
        vectors++;
        if (y !== 4'd6) begin
            miscompares++;
            $display("FAIL bus_drive: y=%b want 0110", y);
        end
        out_en = 1'b0; #1;
        vectors++;
        if ({y, acc} !== {4'hF, 4'd6}) begin
            miscompares++;
            $display("FAIL bus_release2: y=%b acc=%0d, want 1111/6", y, acc);
        end
        out_en = 1'b1;
    endtask

    task automatic test_logic_shift();
        int bc;
        do_op(2, 12, 1'b1, bc);
        do_op(4, 10, 1'b1, bc);
        vectors++;
        if ({acc, carry, zero} !== {4'd7, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL nand: acc=%0d c=%0b z=%0b, want 7/0/0", acc, carry, zero);
        end
        do_op(6, 0, 1'b1, bc);
        vectors++;
        if ({acc, carry} !== {4'd14, 1'b0}) begin
            miscompares++;
            $display("FAIL shl: acc=%0d c=%0b, want 14/0", acc, carry);
        end
        do_op(7, 0, 1'b1, bc);
        vectors++;
        if ({acc, carry} !== {4'd7, 1'b0}) begin
            miscompares++;
            $display("FAIL shr: acc=%0d c=%0b, want 7/0", acc, carry);
        end
        do_op(15, 9, 1'b1, bc);
        vectors++;
        if ({acc, carry, zero} !== {4'd7, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL nop_op15: acc=%0d c=%0b z=%0b, want 7/0/0", acc, carry, zero);
        end
    endtask

    task automatic test_random();
        int bc;
        int op;
        int b;
        bit ben;
        for (int i = 0; i < 80; i++) begin
            op  = (i % 8 == 0) ? 9 : int'($urandom_range(0, 15));
            b   = int'($urandom_range(0, 15));
            ben = ($urandom_range(0, 3) != 0);
            do_op(op, b, ben, bc);
            vectors++;
            if ({acc, carry, zero} !== {m_acc[3:0], m_c[0], m_z[0]}) begin
                miscompares++;
                $display("FAIL random_op%0d i=%0d b=%0d ben=%0b: acc=%0d c=%0b z=%0b, want %0d/%0d/%0d",
                         op, i, b, ben, acc, carry, zero, m_acc, m_c, m_z);
            end
            vectors++;
            if (bc !== ((op == 9) ? 4 : 0)) begin
                miscompares++;
                $display("FAIL random_latency op%0d: busy cycles %0d want %0d",
                         op, bc, (op == 9) ? 4 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_add_chain();
        test_sub_cmp();
        test_mul();
        test_bus();
        test_logic_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
